// File: rtl/bus_ctrl_pkg.sv
// Shared types for the 8088 bus cycle controller: FSM states, region records
// and the single-region address match rule.
package bus_ctrl_pkg;

    localparam int NREG = 4;

    // One-hot so each state bit can be probed directly on the debug output.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_ADDR   = 5'b00010,
        ST_STROBE = 5'b00100,
        ST_WAIT   = 5'b01000,
        ST_DONE   = 5'b10000
    } state_t;

    // One decoded peripheral window. mask bits set to 1 are compared.
    typedef struct packed {
        logic [19:0] base;
        logic [19:0] mask;
        logic        isio;
        logic [2:0]  waits;
    } region_t;

    // A region matches when the compared address bits equal its base and the
    // cycle type (IOM=1 memory, IOM=0 I/O) agrees with the region's kind.
    function automatic logic region_match(input region_t r, input logic [19:0] address,
                                          input logic iom);
        return (((address ^ r.base) & r.mask) == 20'h00000) && (iom == !r.isio);
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// Peripheral-bus bundle between the 8088 side and the cycle controller.
//
// Handshake: ALE high for one clock marks T1 and carries a valid Address/IOM.
// The cycle is then driven by the active-low strobes RD/WR; while READY is low
// the CPU inserts wait states, and the cycle ends when both strobes are high
// again. sel is one-hot (or zero) and stays stable from ALE to cycle end.
interface bus_cycle_ctrl_if;
    import bus_ctrl_pkg::*;

    logic            ALE;
    logic            IOM;
    logic            RD;
    logic            WR;
    logic [19:0]     Address;
    logic [NREG-1:0] sel;
    logic            READY;
    logic            busy;
    logic            miss;
    state_t          dbg_state;

    modport master (
        output ALE, IOM, RD, WR, Address,
        input  sel, READY, busy, miss, dbg_state
    );

    modport slave (
        input  ALE, IOM, RD, WR, Address,
        output sel, READY, busy, miss, dbg_state
    );

endinterface

// File: rtl/bus_cycle_ctrl_region_decode.sv
// Combinational address decoder: matches Address/IOM against a region table
// and resolves overlaps so that the lowest index wins.
module region_decode
    import bus_ctrl_pkg::*;
(
    input  logic [19:0]           address,
    input  logic                  iom,
    input  region_t [NREG-1:0]    regions,
    output logic [NREG-1:0]       sel,
    output logic                  hit,
    output logic [2:0]            waits
);

    // Scan from the highest index down so a lower matching index overwrites.
    always_comb begin
        sel   = '0;
        hit   = 1'b0;
        waits = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (region_match(regions[i], address, iom)) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
                waits  = regions[i].waits;
            end
        end
    end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// Per-bus-cycle chip-select decoder and wait-state sequencer for the 8088
// peripheral bus. Decodes at ALE, holds the select for the cycle, pulls READY
// low for the region's wait states and abandons cycles that never strobe.
module bus_cycle_ctrl
    import bus_ctrl_pkg::*;
#(
    parameter logic [19:0] BASE0   = 20'h00000,
    parameter logic [19:0] BASE1   = 20'h08000,
    parameter logic [19:0] BASE2   = 20'h01C00,
    parameter logic [19:0] BASE3   = 20'hFF000,
    parameter logic [19:0] MASK0   = 20'hF8000,
    parameter logic [19:0] MASK1   = 20'hF8000,
    parameter logic [19:0] MASK2   = 20'hFFC00,
    parameter logic [19:0] MASK3   = 20'hFF000,
    parameter logic        ISIO0   = 1'b0,
    parameter logic        ISIO1   = 1'b0,
    parameter logic        ISIO2   = 1'b1,
    parameter logic        ISIO3   = 1'b0,
    parameter logic [2:0]  WAIT0   = 3'd0,
    parameter logic [2:0]  WAIT1   = 3'd1,
    parameter logic [2:0]  WAIT2   = 3'd2,
    parameter logic [2:0]  WAIT3   = 3'd0,
    parameter int          TIMEOUT = 4
) (
    input logic              CLK,
    input logic              RESET,
    bus_cycle_ctrl_if.slave  bus
);

    localparam region_t [NREG-1:0] REGIONS = {
        region_t'{base: BASE3, mask: MASK3, isio: ISIO3, waits: WAIT3},
        region_t'{base: BASE2, mask: MASK2, isio: ISIO2, waits: WAIT2},
        region_t'{base: BASE1, mask: MASK1, isio: ISIO1, waits: WAIT1},
        region_t'{base: BASE0, mask: MASK0, isio: ISIO0, waits: WAIT0}
    };

    localparam int          TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [NREG-1:0] dec_sel;
    logic            dec_hit;
    logic [2:0]      dec_wait;

    state_t          state;
    logic [NREG-1:0] sel_q;
    logic [2:0]      wait_q;
    logic [2:0]      wcnt;
    logic [TW-1:0]   tcnt;
    logic            miss_q;
    logic            strobe;

    region_decode u_decode (
        .address (bus.Address),
        .iom     (bus.IOM),
        .regions (REGIONS),
        .sel     (dec_sel),
        .hit     (dec_hit),
        .waits   (dec_wait)
    );

    // RD and WR low together still count as one strobe; no arbitration.
    assign strobe = !bus.RD || !bus.WR;

    // Cycle sequencer. ALE always restarts the cycle, whatever the state.
    // A region with N wait states spends N cycles with READY low: the STROBE
    // cycle itself counts as the first, so WAIT only covers the remainder.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            sel_q  <= '0;
            wait_q <= '0;
            wcnt   <= '0;
            tcnt   <= '0;
            miss_q <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            if (bus.ALE) begin
                if (dec_hit) begin
                    state  <= ST_ADDR;
                    sel_q  <= dec_sel;
                    wait_q <= dec_wait;
                    tcnt   <= '0;
                end else begin
                    state  <= ST_IDLE;
                    sel_q  <= '0;
                    miss_q <= 1'b1;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_ADDR: begin
                        if (strobe) begin
                            state <= ST_STROBE;
                            wcnt  <= wait_q;
                        end else if (tcnt == TLAST) begin
                            state <= ST_IDLE;
                            sel_q <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    ST_STROBE: begin
                        if (wcnt > 3'd1) begin
                            state <= ST_WAIT;
                            wcnt  <= wcnt - 3'd1;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                    ST_WAIT: begin
                        wcnt <= wcnt - 3'd1;
                        if (wcnt <= 3'd1) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (!strobe) begin
                            state <= ST_IDLE;
                            sel_q <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        sel_q <= '0;
                    end
                endcase
            end
        end
    end

    // In T1 the peripherals see the live decode alongside ALE; afterwards the
    // latched select keeps them stable even if Address changes.
    assign bus.sel       = (bus.ALE && state == ST_IDLE) ? dec_sel : sel_q;
    assign bus.READY     = !((state == ST_STROBE && wcnt != 3'd0) || state == ST_WAIT);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.miss      = miss_q;
    assign bus.dbg_state = state;

endmodule
